// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch stage.
package ifetch_pkg;

    localparam int DATA_WIDTH = 32;
    localparam logic [DATA_WIDTH-1:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [DATA_WIDTH-1:0] INSTR_BYTES = 32'd4;

    typedef enum logic [2:0] {
        IF_IDLE,
        IF_REQ,
        IF_WAIT,
        IF_ISSUE,
        IF_HALT
    } ifetch_state_t;

endpackage

// File: rtl/ifetch.sv
// ifetch: owns the PC, fetches one word per req/resp handshake and offers it to the decoder;
// redirects from execute squash stale fetches, and a misaligned target halts the stage.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en,
    output logic                  imem_req_valid,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_resp_ready,
    input  logic                  imem_resp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  dec_req_valid,
    output logic [DATA_WIDTH-1:0] dec_instruction,
    output logic [DATA_WIDTH-1:0] dec_pc,
    input  logic                  dec_resp_ready,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  misaligned_err,
    output logic [DATA_WIDTH-1:0] issue_count
);

    ifetch_state_t state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d, instr_q, instr_d, dpc_q, dpc_d, cnt_q, cnt_d;
    logic discard_q, discard_d, err_q, err_d;
    logic redir, mis, req_acc, dec_acc, capture;

    always_comb begin
        redir   = redirect_valid && state_q != IF_IDLE && state_q != IF_HALT;
        mis     = redir && redirect_pc[1:0] != 2'b00;
        req_acc = state_q == IF_REQ && imem_resp_ready;
        dec_acc = state_q == IF_ISSUE && dec_resp_ready && !redirect_valid;
        capture = state_q == IF_WAIT && imem_resp_valid && !discard_q && !redir;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IF_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IF_IDLE:  state_d = fetch_en ? IF_REQ : IF_IDLE;
            IF_REQ:   state_d = req_acc ? IF_WAIT : IF_REQ;
            IF_WAIT:  state_d = !imem_resp_valid ? IF_WAIT : (capture ? IF_ISSUE : IF_REQ);
            IF_ISSUE: state_d = (redir || dec_resp_ready) ? IF_REQ : IF_ISSUE;
            default:  state_d = IF_HALT;
        endcase
        if (mis) state_d = IF_HALT;
    end

    always_comb begin
        imem_req_valid  = state_q == IF_REQ;
        imem_addr       = pc_q;
        dec_req_valid   = state_q == IF_ISSUE && !redirect_valid;
        dec_instruction = instr_q;
        dec_pc          = dpc_q;
        misaligned_err  = err_q;
        issue_count     = cnt_q;
    end

    // A redirect that races an accepted or outstanding request marks its response for discard.
    always_comb begin
        pc_d      = (redir && !mis) ? redirect_pc : (dec_acc ? pc_q + INSTR_BYTES : pc_q);
        instr_d   = capture ? imem_rdata : instr_q;
        dpc_d     = capture ? pc_q : dpc_q;
        cnt_d     = dec_acc ? cnt_q + 32'd1 : cnt_q;
        err_d     = err_q || mis;
        discard_d = discard_q;
        if (state_q == IF_REQ && redir && req_acc) discard_d = 1'b1;
        if (state_q == IF_WAIT) discard_d = imem_resp_valid ? 1'b0 : (discard_q || redir);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            instr_q   <= INSTR_NOP;
            dpc_q     <= RESET_PC;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            dpc_q     <= dpc_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            discard_q <= discard_d;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed checks of the fetch stage with hand-driven memory and decoder handshakes.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en, imem_resp_ready, imem_resp_valid, dec_resp_ready, redirect_valid;
    logic [31:0] imem_rdata, redirect_pc;
    logic        imem_req_valid, dec_req_valid, misaligned_err;
    logic [31:0] imem_addr, dec_instruction, dec_pc, issue_count;
    int          n_checks = 0;
    int          n_fails = 0;

    ifetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .imem_req_valid(imem_req_valid), .imem_addr(imem_addr),
        .imem_resp_ready(imem_resp_ready), .imem_resp_valid(imem_resp_valid),
        .imem_rdata(imem_rdata), .dec_req_valid(dec_req_valid),
        .dec_instruction(dec_instruction), .dec_pc(dec_pc),
        .dec_resp_ready(dec_resp_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .misaligned_err(misaligned_err),
        .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic respond(input logic [31:0] data);
        imem_resp_valid = 1'b1;
        imem_rdata      = data;
        tick();
        imem_resp_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; fetch_en = 1'b0; imem_resp_ready = 1'b0; imem_resp_valid = 1'b0;
        dec_resp_ready = 1'b0; redirect_valid = 1'b0; imem_rdata = '0; redirect_pc = '0;
        tick(); tick();
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_dec_valid", {31'd0, dec_req_valid}, 32'd0);
        chk("rst_instr", dec_instruction, 32'h0000_0013);
        chk("rst_dec_pc", dec_pc, 32'h0);
        chk("rst_count", issue_count, 32'd0);
        chk("rst_err", {31'd0, misaligned_err}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("idle_hold", {31'd0, imem_req_valid}, 32'd0);
        fetch_en = 1'b1; imem_resp_ready = 1'b1;
        tick();
        chk("t1_first_req", {31'd0, imem_req_valid}, 32'd1);
        chk("t1_first_addr", imem_addr, 32'h0);
        // Test 1: three sequential fetches with 2-cycle memory latency
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_req_drop", {31'd0, imem_req_valid}, 32'd0);
            tick();
            respond(32'hA000_0000 + i);
            chk("t1_dec_valid", {31'd0, dec_req_valid}, 32'd1);
            chk("t1_instr", dec_instruction, 32'hA000_0000 + i);
            chk("t1_dec_pc", dec_pc, 32'(4 * i));
            dec_resp_ready = 1'b1;
            tick();
            dec_resp_ready = 1'b0;
            chk("t1_next_req", {31'd0, imem_req_valid}, 32'd1);
            chk("t1_next_addr", imem_addr, 32'(4 * (i + 1)));
            chk("t1_count", issue_count, 32'(i + 1));
        end
        // Test 2: decoder stall in ISSUE
        tick();
        respond(32'h0000_000B);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_dec_valid", {31'd0, dec_req_valid}, 32'd1);
            chk("t2_instr", dec_instruction, 32'h0000_000B);
            chk("t2_dec_pc", dec_pc, 32'h0000_000C);
            chk("t2_no_req", {31'd0, imem_req_valid}, 32'd0);
        end
        dec_resp_ready = 1'b1;
        tick();
        dec_resp_ready = 1'b0;
        chk("t2_addr", imem_addr, 32'h10);
        chk("t2_count", issue_count, 32'd4);
        // Test 3: redirect while waiting for the 0x10 response
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk("t3_wait_addr", imem_addr, 32'h100);
        chk("t3_wait_noreq", {31'd0, imem_req_valid}, 32'd0);
        respond(32'hDEAD_BEEF);
        chk("t3_dropped", {31'd0, dec_req_valid}, 32'd0);
        chk("t3_req", {31'd0, imem_req_valid}, 32'd1);
        chk("t3_req_addr", imem_addr, 32'h100);
        tick();
        respond(32'h0000_000C);
        chk("t3_dec_valid", {31'd0, dec_req_valid}, 32'd1);
        chk("t3_dec_pc", dec_pc, 32'h100);
        chk("t3_instr", dec_instruction, 32'h0000_000C);
        dec_resp_ready = 1'b1;
        tick();
        dec_resp_ready = 1'b0;
        chk("t3_count", issue_count, 32'd5);
        chk("t3_next_addr", imem_addr, 32'h104);
        // Test 4: redirect in ISSUE while decoder is ready
        tick();
        respond(32'h0000_000D);
        dec_resp_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        #1;
        chk("t4_forced_low", {31'd0, dec_req_valid}, 32'd0);
        tick();
        dec_resp_ready = 1'b0; redirect_valid = 1'b0;
        chk("t4_count", issue_count, 32'd5);
        chk("t4_addr", imem_addr, 32'h40);
        chk("t4_req", {31'd0, imem_req_valid}, 32'd1);
        // Redirect racing an accepted request discards its response
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick();
        redirect_valid = 1'b0;
        chk("race_addr", imem_addr, 32'h80);
        chk("race_wait", {31'd0, imem_req_valid}, 32'd0);
        respond(32'h0000_000E);
        chk("race_dropped", {31'd0, dec_req_valid}, 32'd0);
        chk("race_req_addr", imem_addr, 32'h80);
        // Redirect in REQ without acceptance, then a stray response in REQ
        imem_resp_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h60;
        tick();
        redirect_valid = 1'b0;
        chk("noacc_addr", imem_addr, 32'h60);
        chk("noacc_req", {31'd0, imem_req_valid}, 32'd1);
        respond(32'h0000_00FF);
        chk("stray_ignored", {31'd0, dec_req_valid}, 32'd0);
        chk("stray_req", {31'd0, imem_req_valid}, 32'd1);
        // Test 5: misaligned redirect halts
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect_valid = 1'b0;
        chk("t5_err", {31'd0, misaligned_err}, 32'd1);
        chk("t5_req", {31'd0, imem_req_valid}, 32'd0);
        chk("t5_dec", {31'd0, dec_req_valid}, 32'd0);
        chk("t5_pc", imem_addr, 32'h60);
        imem_resp_ready = 1'b1;
        tick(); tick(); tick();
        chk("t5_halted_req", {31'd0, imem_req_valid}, 32'd0);
        chk("t5_halted_err", {31'd0, misaligned_err}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_err", {31'd0, misaligned_err}, 32'd0);
        rst_n = 1'b1;
        // Test 6: async reset in WAIT, then a late response
        tick();
        chk("t6_req", {31'd0, imem_req_valid}, 32'd1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req", {31'd0, imem_req_valid}, 32'd0);
        chk("t6_rst_instr", dec_instruction, 32'h0000_0013);
        chk("t6_rst_count", issue_count, 32'd0);
        chk("t6_rst_addr", imem_addr, 32'h0);
        fetch_en = 1'b0;
        tick();
        rst_n = 1'b1;
        respond(32'h0000_00F0);
        chk("t6_late_dec", {31'd0, dec_req_valid}, 32'd0);
        chk("t6_late_instr", dec_instruction, 32'h0000_0013);
        chk("t6_late_req", {31'd0, imem_req_valid}, 32'd0);
        fetch_en = 1'b1;
        tick();
        chk("t6_restart_req", {31'd0, imem_req_valid}, 32'd1);
        chk("t6_restart_addr", imem_addr, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
